instruction_fetch_queue: RTL and testbench
==========================================

Name: instruction_fetch_queue

Overview:
- PC generator and fetch buffer sitting directly upstream of the instruction memory.
- Drives the fetch PC into the instruction memory and captures the combinational instruction word returned in the same cycle.
- Buffers up to DEPTH {pc, instruction} pairs in a FIFO for the decode stage.
- Handles branch/jump redirects by flushing the buffer and reloading the PC.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, PC loaded on reset
MEM_BYTES, 1024, instruction memory size in bytes; power of two; PC wraps modulo this value

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
pc  output  32  fetch address to instruction memory (byte address, word aligned)
inst_in  input  32  instruction word from instruction memory for the current pc (same-cycle, combinational)
redirect_valid  input  1  branch/jump taken; load redirect_pc
redirect_pc  input  32  redirect target
deq_ready  input  1  decode accepts the head entry this cycle
deq_valid  output  1  head entry valid
deq_inst  output  32  head instruction
deq_pc  output  32  PC of head instruction
count  output  $clog2(DEPTH+1)  occupied entries
full  output  1  count == DEPTH

Behaviour:
- Reset (synchronous, active-high):
  - pc <= RESET_PC; queue emptied; count=0; deq_valid=0; full=0.
  - deq_inst and deq_pc = 0.
  - Reset mid-operation discards all entries and ignores redirect in the same cycle.
- pop: deq_valid & deq_ready.
- push: !redirect_valid & (!full | pop). Writes {pc, inst_in} at the tail; next cycle pc <= (pc + 4) mod MEM_BYTES.
- No push: pc holds.
- Full with pop in the same cycle: push allowed; count unchanged.
- Empty: deq_valid=0; a pop is impossible (see optional feature for bypass).
- Redirect (priority over push and pop):
  - Queue flushed (count <= 0); no push that cycle.
  - pc <= {redirect_pc[31:2], 2'b00} mod MEM_BYTES; misaligned low bits are dropped.
  - The head offered that cycle is not consumed, even if deq_ready=1.
- Latency: an instruction fetched at cycle N appears on deq_* at cycle N+1 at the earliest. Redirect to first deq_valid is 2 cycles.
- deq_inst and deq_pc are driven from the head storage flops; stable while deq_valid & !deq_ready.
- Pointers: log2(DEPTH) bits; wrap naturally; count = pushes - pops; never exceeds DEPTH, never underflows.
- PC wrap: pc = MEM_BYTES-4 followed by a push → next pc = 0.
- pc is always a registered output with no combinational path from the inputs.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- When defined:
  - If the queue is empty, !redirect_valid and deq_ready: deq_valid=1, deq_inst=inst_in, deq_pc=pc combinationally.
  - The word is consumed directly without being written; pc advances; count stays 0.
  - Zero-cycle fetch-to-decode latency when decode is never stalled.
- When undefined: empty queue → deq_valid=0; minimum latency is 1 cycle as above.

Test Plan:
- Memory model inst_in = 32'hA000_0000 | pc. Reset held 2 cycles, then released with deq_ready=1 → deq_* sequence (pc 0, inst A000_0000), (4, A000_0004), (8, A000_0008) … one per cycle from the cycle after release; pc increments by 4 each cycle.
- deq_ready=0 for 6 cycles after reset → count reaches 4, full=1, pc frozen at 16. Then deq_ready=1 → entries pc 0,4,8,12 pop in order; pc resumes at 16.
- Full queue, deq_ready=1 for one cycle → count stays 4 and pc advances by 4 (push and pop coincide).
- redirect_valid=1, redirect_pc=32'h0000_0043, queue holding 3 entries → next cycle count=0, pc=32'h40, deq_valid=0; following cycle deq_pc=32'h40, deq_inst=A000_0040.
- Sequential fetch from pc=1020 (MEM_BYTES-4) → next pc=0. Reset asserted while full and redirect active → next cycle count=0, pc=RESET_PC.
- With FETCH_BYPASS_EN and deq_ready=1 after reset → deq_valid=1 in the first post-reset cycle with deq_pc=0, count remains 0. Without the macro → deq_valid=0 in that cycle.

Source files
------------

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-queue handshake bundle: memory-side pc/instruction, redirect, and decode-side dequeue.
// Latency: none (wires only); master is the fetch queue, slave is memory plus decode.
// Backpressure: deq_ready from decode stalls the queue; full indicates the queue has no free entry.
interface instruction_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc;
  logic [31:0]   inst_in;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          deq_ready;
  logic          deq_valid;
  logic [31:0]   deq_inst;
  logic [31:0]   deq_pc;
  logic [CW-1:0] count;
  logic          full;

  modport master (
    output pc, deq_valid, deq_inst, deq_pc, count, full,
    input  inst_in, redirect_valid, redirect_pc, deq_ready
  );

  modport slave (
    input  pc, deq_valid, deq_inst, deq_pc, count, full,
    output inst_in, redirect_valid, redirect_pc, deq_ready
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// PC generator and DEPTH-entry {pc, inst} buffer in front of decode; FETCH_BYPASS_EN adds an empty-queue bypass.
// Latency: fetch to deq_* is 1 cycle (0 with bypass when decode is ready); redirect to first deq_valid is 2 cycles.
// Backpressure: deq_ready low fills the queue; when it is full the pc freezes until a pop frees a slot.
module instruction_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024
) (
  input logic                    clk,
  input logic                    reset,
  instruction_fetch_queue_if.master fq
);
  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [31:0] PC_MASK = 32'(MEM_BYTES - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic [31:0]   pc_q;

  logic empty;
  logic full_i;
  logic bypass;
  logic pop;
  logic push;
  logic wr_en;

  // Handshake decode: redirect overrides both push and pop; bypass consumes the fetched word without storing it.
  always_comb begin
    empty  = (cnt == '0);
    full_i = (cnt == CW'(DEPTH));
`ifdef FETCH_BYPASS_EN
    bypass = empty & !fq.redirect_valid & fq.deq_ready;
`else
    bypass = 1'b0;
`endif
    pop    = !empty & fq.deq_ready & !fq.redirect_valid;
    push   = !fq.redirect_valid & (!full_i | pop);
    wr_en  = push & !bypass;
  end

  // Head presentation: stored head normally, the live memory word when bypassing an empty queue.
  always_comb begin
    fq.deq_valid = !empty | bypass;
    fq.deq_inst  = mem[rd_ptr].inst;
    fq.deq_pc    = mem[rd_ptr].pc;
    if (bypass) begin
      fq.deq_inst = fq.inst_in;
      fq.deq_pc   = pc_q;
    end
  end

  assign fq.pc    = pc_q;
  assign fq.count = cnt;
  assign fq.full  = full_i;

  // Pointer, occupancy and pc state; reset beats redirect, redirect flushes and reloads the pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      pc_q   <= RESET_PC;
    end else if (fq.redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      pc_q   <= {fq.redirect_pc[31:2], 2'b00} & PC_MASK;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(wr_en) - CW'(pop);
      if (push)  pc_q <= (pc_q + 32'd4) & PC_MASK;
    end
  end

  // Entry storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= '{pc: pc_q, inst: fq.inst_in};
    end
  end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue with a pc-derived instruction memory model.
// Latency: expectations are per cycle, sampled 1 time unit after each rising edge.
// Backpressure: deq_ready is held low in places to fill the queue and check full/pc freeze.
module tb_instruction_fetch_queue;
  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  instruction_fetch_queue_if #(.DEPTH(DEPTH)) fif ();

  instruction_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(1024)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .fq   (fif.master)
  );

  // Instruction memory: each word encodes its own address.
  assign fif.inst_in = 32'hA000_0000 | fif.pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic rdy);
    fif.redirect_valid = 1'b0;
    fif.redirect_pc    = 32'h0;
    fif.deq_ready      = 1'b0;
    reset              = 1'b1;
    step();
    step();
    reset         = 1'b0;
    fif.deq_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    checks++; if (fif.pc !== 32'h0) $display("FAIL reset_pc got %h want %h", fif.pc, 32'h0); else passed++;
    checks++; if (fif.count !== 3'd0) $display("FAIL reset_count got %0d want 0", fif.count); else passed++;
    checks++; if (fif.deq_valid !== 1'b0) $display("FAIL reset_deq_valid got %b want 0", fif.deq_valid); else passed++;
    checks++; if (fif.full !== 1'b0) $display("FAIL reset_full got %b want 0", fif.full); else passed++;
    checks++; if (fif.deq_pc !== 32'h0) $display("FAIL reset_deq_pc got %h want 0", fif.deq_pc); else passed++;
    checks++; if (fif.deq_inst !== 32'h0) $display("FAIL reset_deq_inst got %h want 0", fif.deq_inst); else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    logic [31:0] exp_head;
    apply_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      exp_pc   = 32'(4 * (i + 1));
      exp_head = BYP ? exp_pc : 32'(4 * i);
      checks++; if (fif.deq_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b want 1", i, fif.deq_valid); else passed++;
      checks++; if (fif.deq_pc !== exp_head) $display("FAIL stream_deq_pc[%0d] got %h want %h", i, fif.deq_pc, exp_head); else passed++;
      checks++; if (fif.deq_inst !== (32'hA000_0000 | exp_head)) $display("FAIL stream_deq_inst[%0d] got %h want %h", i, fif.deq_inst, 32'hA000_0000 | exp_head); else passed++;
      checks++; if (fif.pc !== exp_pc) $display("FAIL stream_pc[%0d] got %h want %h", i, fif.pc, exp_pc); else passed++;
    end
  endtask

  task automatic test_full();
    int n;
    apply_reset(1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      n = (k < 4) ? k : 4;
      checks++; if (fif.count !== 3'(n)) $display("FAIL fill_count[%0d] got %0d want %0d", k, fif.count, n); else passed++;
      checks++; if (fif.pc !== 32'(4 * n)) $display("FAIL fill_pc[%0d] got %h want %h", k, fif.pc, 32'(4 * n)); else passed++;
      checks++; if (fif.full !== (k >= 4)) $display("FAIL fill_full[%0d] got %b want %b", k, fif.full, k >= 4); else passed++;
    end
    fif.deq_ready = 1'b1;
    #1;
    checks++; if (fif.deq_pc !== 32'h0) $display("FAIL drain_head0 got %h want 0", fif.deq_pc); else passed++;
    for (int j = 1; j <= 3; j++) begin
      step();
      checks++; if (fif.count !== 3'd4) $display("FAIL drain_count[%0d] got %0d want 4", j, fif.count); else passed++;
      checks++; if (fif.pc !== 32'(16 + 4 * j)) $display("FAIL drain_pc[%0d] got %h want %h", j, fif.pc, 32'(16 + 4 * j)); else passed++;
      checks++; if (fif.deq_pc !== 32'(4 * j)) $display("FAIL drain_deq_pc[%0d] got %h want %h", j, fif.deq_pc, 32'(4 * j)); else passed++;
    end
    fif.deq_ready = 1'b0;
  endtask

  task automatic test_redirect();
    apply_reset(1'b0);
    step(); step(); step();
    checks++; if (fif.count !== 3'd3) $display("FAIL redir_pre_count got %0d want 3", fif.count); else passed++;
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 32'h0000_0043;
    fif.deq_ready      = 1'b1;
    step();
    fif.redirect_valid = 1'b0;
    fif.deq_ready      = 1'b0;
    #1;
    checks++; if (fif.count !== 3'd0) $display("FAIL redir_count got %0d want 0", fif.count); else passed++;
    checks++; if (fif.pc !== 32'h40) $display("FAIL redir_pc got %h want 00000040", fif.pc); else passed++;
    checks++; if (fif.deq_valid !== 1'b0) $display("FAIL redir_deq_valid got %b want 0", fif.deq_valid); else passed++;
    step();
    checks++; if (fif.deq_valid !== 1'b1) $display("FAIL redir_first_valid got %b want 1", fif.deq_valid); else passed++;
    checks++; if (fif.deq_pc !== 32'h40) $display("FAIL redir_first_pc got %h want 00000040", fif.deq_pc); else passed++;
    checks++; if (fif.deq_inst !== 32'hA000_0040) $display("FAIL redir_first_inst got %h want a0000040", fif.deq_inst); else passed++;
    checks++; if (fif.count !== 3'd1) $display("FAIL redir_first_count got %0d want 1", fif.count); else passed++;
  endtask

  task automatic test_pc_wrap();
    fif.deq_ready      = 1'b0;
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 32'h0000_03FE;
    step();
    fif.redirect_valid = 1'b0;
    #1;
    checks++; if (fif.pc !== 32'h3FC) $display("FAIL wrap_start_pc got %h want 000003fc", fif.pc); else passed++;
    step();
    checks++; if (fif.pc !== 32'h0) $display("FAIL wrap_pc got %h want 0", fif.pc); else passed++;
    checks++; if (fif.deq_pc !== 32'h3FC) $display("FAIL wrap_deq_pc got %h want 000003fc", fif.deq_pc); else passed++;
    checks++; if (fif.deq_inst !== 32'hA000_03FC) $display("FAIL wrap_deq_inst got %h want a00003fc", fif.deq_inst); else passed++;
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 32'h0000_1408;
    step();
    fif.redirect_valid = 1'b0;
    #1;
    checks++; if (fif.pc !== 32'h8) $display("FAIL wrap_redir_pc got %h want 00000008", fif.pc); else passed++;
  endtask

  task automatic test_reset_mid();
    apply_reset(1'b0);
    step(); step(); step(); step(); step();
    checks++; if (fif.full !== 1'b1) $display("FAIL mid_pre_full got %b want 1", fif.full); else passed++;
    reset              = 1'b1;
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 32'h0000_0080;
    step();
    reset              = 1'b0;
    fif.redirect_valid = 1'b0;
    #1;
    checks++; if (fif.count !== 3'd0) $display("FAIL mid_count got %0d want 0", fif.count); else passed++;
    checks++; if (fif.pc !== 32'h0) $display("FAIL mid_pc got %h want 0", fif.pc); else passed++;
    checks++; if (fif.full !== 1'b0) $display("FAIL mid_full got %b want 0", fif.full); else passed++;
    checks++; if (fif.deq_valid !== 1'b0) $display("FAIL mid_deq_valid got %b want 0", fif.deq_valid); else passed++;
    checks++; if (fif.deq_pc !== 32'h0) $display("FAIL mid_deq_pc got %h want 0", fif.deq_pc); else passed++;
    checks++; if (fif.deq_inst !== 32'h0) $display("FAIL mid_deq_inst got %h want 0", fif.deq_inst); else passed++;
  endtask

  task automatic test_bypass();
    apply_reset(1'b0);
    fif.deq_ready = 1'b1;
    #1;
    checks++; if (fif.deq_valid !== BYP) $display("FAIL byp_valid got %b want %b", fif.deq_valid, BYP); else passed++;
    checks++; if (fif.deq_pc !== 32'h0) $display("FAIL byp_deq_pc got %h want 0", fif.deq_pc); else passed++;
    checks++; if (fif.count !== 3'd0) $display("FAIL byp_count got %0d want 0", fif.count); else passed++;
    step();
    checks++; if (fif.count !== (BYP ? 3'd0 : 3'd1)) $display("FAIL byp_next_count got %0d want %0d", fif.count, BYP ? 0 : 1); else passed++;
    checks++; if (fif.pc !== 32'h4) $display("FAIL byp_next_pc got %h want 00000004", fif.pc); else passed++;
    fif.deq_ready = 1'b0;
  endtask

  initial begin
    checks             = 0;
    passed             = 0;
    reset              = 1'b1;
    fif.redirect_valid = 1'b0;
    fif.redirect_pc    = 32'h0;
    fif.deq_ready      = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_pc_wrap();
    test_reset_mid();
    test_bypass();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
